// File: rtl/booth_r2_mul_param_if.sv
// Operand/result bundle for the radix-2 Booth multiplier.
// The master side drives the operands and load; the slave (multiplier) returns P, busy and done.
interface booth_r2_mul_param_if #(
  parameter int WIDTH = 4
);
  logic                 load;
  logic                 signed_mode;
  logic [WIDTH-1:0]     M;
  logic [WIDTH-1:0]     Q;
  logic [2*WIDTH-1:0]   P;
  logic                 busy;
  logic                 done;

  modport master (
    output load,
    output signed_mode,
    output M,
    output Q,
    input  P,
    input  busy,
    input  done
  );

  modport slave (
    input  load,
    input  signed_mode,
    input  M,
    input  Q,
    output P,
    output busy,
    output done
  );
endinterface

// File: rtl/booth_r2_mul_param.sv
// Sequential radix-2 Booth multiplier with parameterised width and a signed/unsigned mode.
// Operands are widened by one bit so that one Booth datapath serves both modes; one step per clock.
module booth_r2_mul_param #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  booth_r2_mul_param_if.slave   bus
);
  localparam int E  = WIDTH + 1;
  localparam int CW = $clog2(E + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state, state_next;
  logic [E-1:0]   a, a_next;
  logic [E-1:0]   qr, qr_next;
  logic [E-1:0]   mr, mr_next;
  logic           q1, q1_next;
  logic [CW-1:0]  count, count_next;
  logic [2*WIDTH-1:0] p, p_next;
  logic           done_r, done_next;
  logic [E-1:0]   sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      a      <= '0;
      qr     <= '0;
      mr     <= '0;
      q1     <= 1'b0;
      count  <= '0;
      p      <= '0;
      done_r <= 1'b0;
    end else begin
      state  <= state_next;
      a      <= a_next;
      qr     <= qr_next;
      mr     <= mr_next;
      q1     <= q1_next;
      count  <= count_next;
      p      <= p_next;
      done_r <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    a_next     = a;
    qr_next    = qr;
    mr_next    = mr;
    q1_next    = q1;
    count_next = count;
    p_next     = p;
    done_next  = 1'b0;
    sum        = a;

    case (state)
      IDLE: begin
        if (bus.load) begin
          // The extra top bit makes unsigned operands look like positive signed values.
          mr_next    = bus.signed_mode ? {bus.M[WIDTH-1], bus.M} : {1'b0, bus.M};
          qr_next    = bus.signed_mode ? {bus.Q[WIDTH-1], bus.Q} : {1'b0, bus.Q};
          a_next     = '0;
          q1_next    = 1'b0;
          count_next = CW'(E);
          state_next = RUN;
        end
      end

      RUN: begin
        case ({qr[0], q1})
          2'b01:   sum = a + mr;
          2'b10:   sum = a - mr;
          default: sum = a;
        endcase

        a_next     = {sum[E-1], sum[E-1:1]};
        qr_next    = {sum[0], qr[E-1:1]};
        q1_next    = qr[0];
        count_next = count - CW'(1);

        // The product of two E-bit values always fits in the low 2*WIDTH bits here.
        if (count == CW'(1)) begin
          p_next     = {a_next[E-3:0], qr_next};
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.P    = p;
  assign bus.busy = (state == RUN);
  assign bus.done = done_r;
endmodule

// File: tb/tb_booth_r2_mul_param.sv
// Scoreboard bench for booth_r2_mul_param at WIDTH=4 and WIDTH=8 against an integer-arithmetic model.
module tb_booth_r2_mul_param;
  typedef struct {
    logic [31:0] p;
    int          due;
  } exp_t;

  logic clk;
  logic rst4, rst8;
  int   cyc;
  int   checks, errors;
  int   last_due;
  bit   checking;
  bit   due4, due8;
  exp_t sb4[$];
  exp_t sb8[$];
  logic [31:0] exp_p4, exp_p8;

  booth_r2_mul_param_if #(.WIDTH(4)) bus4 ();
  booth_r2_mul_param_if #(.WIDTH(8)) bus8 ();

  booth_r2_mul_param #(.WIDTH(4)) dut4 (.clk(clk), .reset(rst4), .bus(bus4));
  booth_r2_mul_param #(.WIDTH(8)) dut8 (.clk(clk), .reset(rst8), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: interpret operands as integers, multiply, keep the low 2*w bits.
  function automatic logic [31:0] ref_product(input int w, input logic [15:0] m,
                                              input logic [15:0] q, input bit sgn);
    longint mv, qv, pr, one;
    one = 64'sd1;
    mv = longint'(m) & ((one << w) - 1);
    qv = longint'(q) & ((one << w) - 1);
    if (sgn && mv >= (one << (w - 1))) mv = mv - (one << w);
    if (sgn && qv >= (one << (w - 1))) qv = qv - (one << w);
    pr = mv * qv;
    return 32'(pr & ((one << (2 * w)) - 1));
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, actual, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input int w, input logic [15:0] m, input logic [15:0] q,
                                input bit mode);
    exp_t e;
    if (w == 4) begin
      bus4.M = m[3:0]; bus4.Q = q[3:0]; bus4.signed_mode = mode; bus4.load = 1'b1;
    end else begin
      bus8.M = m[7:0]; bus8.Q = q[7:0]; bus8.signed_mode = mode; bus8.load = 1'b1;
    end
    @(posedge clk);
    #1;
    e.p   = ref_product(w, m, q, mode);
    e.due = cyc + w + 1;
    last_due = e.due;
    // Scramble the operands after capture; they must not affect the running operation.
    if (w == 4) begin
      bus4.load = 1'b0; bus4.M = 4'($urandom); bus4.Q = 4'($urandom);
      bus4.signed_mode = 1'($urandom);
      sb4.push_back(e);
    end else begin
      bus8.load = 1'b0; bus8.M = 8'($urandom); bus8.Q = 8'($urandom);
      bus8.signed_mode = 1'($urandom);
      sb8.push_back(e);
    end
  endtask

  task automatic poke_while_busy(input int w);
    if (w == 4) begin
      bus4.load = 1'b1; bus4.M = 4'($urandom); bus4.Q = 4'($urandom);
    end else begin
      bus8.load = 1'b1; bus8.M = 8'($urandom); bus8.Q = 8'($urandom);
    end
    idle(1);
    bus4.load = 1'b0;
    bus8.load = 1'b0;
  endtask

  task automatic wait_done();
    while (cyc < last_due) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic print_summary();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
  endtask

  // Monitor: every cycle compare done, busy and P of both instances with the scoreboard.
  always @(negedge clk) begin
    if (checking) begin
      due4 = (sb4.size() > 0) && (sb4[0].due == cyc);
      check_output("w4_done", 32'(bus4.done), 32'(due4));
      check_output("w4_busy", 32'(bus4.busy), 32'((sb4.size() > 0) && (cyc < sb4[0].due)));
      if (due4) begin
        exp_p4 = sb4[0].p;
        void'(sb4.pop_front());
      end
      check_output("w4_P", 32'(bus4.P), exp_p4);

      due8 = (sb8.size() > 0) && (sb8[0].due == cyc);
      check_output("w8_done", 32'(bus8.done), 32'(due8));
      check_output("w8_busy", 32'(bus8.busy), 32'((sb8.size() > 0) && (cyc < sb8[0].due)));
      if (due8) begin
        exp_p8 = sb8[0].p;
        void'(sb8.pop_front());
      end
      check_output("w8_P", 32'(bus8.P), exp_p8);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    errors++;
    print_summary();
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int gap;
    checks = 0; errors = 0; checking = 1'b0; last_due = 0;
    exp_p4 = '0; exp_p8 = '0;
    rst4 = 1'b1; rst8 = 1'b1;
    bus4.load = 1'b0; bus4.M = '0; bus4.Q = '0; bus4.signed_mode = 1'b0;
    bus8.load = 1'b0; bus8.M = '0; bus8.Q = '0; bus8.signed_mode = 1'b0;
    idle(2);
    rst4 = 1'b0; rst8 = 1'b0;
    checking = 1'b1;
    $display("[TB] reset released");

    // Signed -6 * -5, then signed corners back to back in the done cycle.
    apply_stimulus(4, 16'hA, 16'hB, 1'b1); wait_done();
    apply_stimulus(4, 16'h8, 16'h8, 1'b1); wait_done();
    apply_stimulus(4, 16'h8, 16'h7, 1'b1); wait_done();
    apply_stimulus(4, 16'h0, 16'hF, 1'b1); wait_done();
    idle(1);

    // Unsigned mode, including bits that mean something else when signed.
    apply_stimulus(4, 16'hF, 16'hF, 1'b0); wait_done();
    idle(2);
    apply_stimulus(4, 16'hA, 16'hB, 1'b0); wait_done();
    idle(1);

    // Load while busy is ignored.
    apply_stimulus(4, 16'h3, 16'h3, 1'b0);
    idle(1);
    bus4.load = 1'b1; bus4.M = 4'h5; bus4.Q = 4'h5;
    idle(1);
    bus4.load = 1'b0;
    wait_done();
    idle(1);

    // Reset mid-operation aborts the result, then a fresh load works.
    apply_stimulus(4, 16'h7, 16'h7, 1'b1);
    idle(1);
    rst4 = 1'b1;
    idle(1);
    rst4 = 1'b0;
    sb4.delete();
    exp_p4 = '0;
    idle(7);
    apply_stimulus(4, 16'h2, 16'h3, 1'b1); wait_done();
    idle(1);

    // WIDTH=8 extremes.
    apply_stimulus(8, 16'h80, 16'h80, 1'b1); wait_done();
    apply_stimulus(8, 16'd100, 16'hFFFD, 1'b1); wait_done();
    apply_stimulus(8, 16'hFF, 16'hFF, 1'b0); wait_done();
    idle(1);

    $display("[TB] random phase");
    for (int w = 4; w <= 8; w += 4) begin
      for (int i = 0; i < 16; i++) begin
        apply_stimulus(w, 16'($urandom), 16'($urandom), 1'($urandom));
        if ($urandom_range(0, 3) == 0) poke_while_busy(w);
        wait_done();
        gap = $urandom_range(0, 2);
        idle(gap);
      end
      idle(1);
    end

    idle(3);
    check_output("w4_drained", 32'(sb4.size()), 32'd0);
    check_output("w8_drained", 32'(sb8.size()), 32'd0);
    checking = 1'b0;
    print_summary();
    $finish;
  end
endmodule
